fb_rect_writer: RTL and testbench
=================================

Name: fb_rect_writer

Overview:
- Drawing engine that writes solid-colour rectangles into the 320x240, 12-bit-per-pixel frame buffer that the VGA scan-out path reads.
- Accepts one rectangle command per start pulse, clips it to the screen, and emits one pixel write per granted cycle in raster order.
- Drives the frame-buffer write port (wea/addra/dina) through an external arbiter that grants write cycles.

Parameters:
FB_W, 320, frame-buffer width in pixels
FB_H, 240, frame-buffer height in pixels
ADDR_W, 17, frame-buffer address width (FB_W*FB_H <= 2^ADDR_W)
COLOR_W, 12, pixel width ({R,G,B} 4 bits each)

Ports:
clk  in  1  system clock; all state changes on its rising edge
rst  in  1  reset, asynchronous, active-low (rst=0 resets)
start  in  1  command strobe; sampled only in IDLE
x0  in  9  left column, 0..511
y0  in  8  top row, 0..255
w  in  9  width in pixels
h  in  8  height in pixels
color  in  COLOR_W  fill colour
busy  out  1  high from command accept until done
done  out  1  one-cycle pulse when the command completes
fb_we  out  1  write request to the frame buffer
fb_gnt  in  1  arbiter grant; a write commits in a cycle where fb_we=1 and fb_gnt=1
fb_addr  out  ADDR_W  pixel address = y*FB_W + x
fb_data  out  COLOR_W  pixel value

Behaviour:
- Reset values: busy=0, done=0, fb_we=0, fb_addr=0, fb_data=0, state=IDLE. Reset mid-command aborts immediately with no further writes.
- States: IDLE, SETUP, WRITE, FINISH.
- IDLE: when start=1, latch x0, y0, w, h and color, set busy=1, and go to SETUP. When start=0, stay in IDLE.
- SETUP (1 cycle): clip the command.
  - xe = min(x0+w, FB_W); ye = min(y0+h, FB_H). Compute the sums at 10 bits so they cannot overflow.
  - If w=0, h=0, x0>=FB_W or y0>=FB_H, the rectangle is empty: go to FINISH with no writes.
  - Otherwise set row_base = y0*FB_W using shift-add (y*256 + y*64, no multiplier), set fb_addr = row_base + x0, and go to WRITE.
- WRITE:
  - fb_we=1 with fb_data=latched colour.
  - fb_addr, fb_we and fb_data stay stable while fb_gnt=0.
  - On a grant, advance x. At x=xe-1, wrap x to the latched x0, add FB_W to row_base and advance y.
  - On the grant for the last pixel (x=xe-1, y=ye-1), drop fb_we the next cycle and go to FINISH.
- FINISH: done=1 for one cycle, busy=0 in the same cycle, then IDLE. A new start is accepted the cycle after FINISH.
- start while busy is ignored and does not queue.
- Latency: with fb_gnt tied high, the first fb_we occurs 2 cycles after start, and done occurs 2 + N cycles after start, where N is the clipped pixel count.
- Throughput: one pixel per granted cycle.
- fb_addr never exceeds FB_W*FB_H-1.

Optional Feature:
- Macro: FB_RECT_OUTLINE_EN.
- Defined:
  - Adds input port outline (1 bit), latched with the command.
  - When outline=1, only pixels on the first or last clipped row, or the first or last clipped column, are written.
  - Interior pixels are skipped at zero cycle cost: the address jumps from column x0 straight to column xe-1.
  - Clipped-away edges are not drawn.
- Undefined: the port is absent and every command is a solid fill.

Decomposition:
- Package fb_pkg holds FB_W, FB_H, ADDR_W, COLOR_W, the state enum (IDLE/SETUP/WRITE/FINISH), and a colour typedef shared with the scan-out address generator.
- No sub-module is required. The clip/SETUP arithmetic stays inline; optionally split it out as fb_rect_clip (pure combinational).

Test Plan:
- Basic fill, fb_gnt=1: x0=10, y0=5, w=3, h=2, color=12'hF00.
  - Writes 1610,1611,1612,1930,1931,1932, all with data F00.
  - done at start+8.
- Clip at corner: x0=318, y0=239, w=5, h=5.
  - Writes only 76798 and 76799.
  - done pulses once; busy low afterwards.
- Empty commands: w=0; then separately x0=320.
  - No fb_we assertions.
  - done exactly 2 cycles after start.
- Stall: fb_gnt toggles in a 1-of-3 pattern during a 4x1 fill at address 0.
  - Addresses 0..3 each held until granted, no skips or duplicates.
  - start pulses while busy are ignored.
- Reset mid-command: rst=0 during WRITE.
  - fb_we drops asynchronously with no further writes.
  - After release, a new command executes correctly.
- FB_RECT_OUTLINE_EN: x0=0, y0=0, w=4, h=3, outline=1.
  - Writes 0,1,2,3,320,323,640,641,642,643 only.

Source files
------------

// File: rtl/fb_pkg.sv
// fb_pkg: frame-buffer geometry and drawing-engine types,
// shared with the scan-out address generator.
package fb_pkg;

  localparam int FB_W    = 320;
  localparam int FB_H    = 240;
  localparam int ADDR_W  = 17;
  localparam int COLOR_W = 12;

  typedef logic [COLOR_W-1:0] color_t;
  typedef logic [ADDR_W-1:0]  addr_t;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    WRITE,
    FINISH
  } state_t;

  // y*320 as y*256 + y*64, no multiplier
  function automatic addr_t row_addr(input logic [7:0] y);
    return addr_t'({y, 8'b0}) + addr_t'({y, 6'b0});
  endfunction

endpackage

// File: rtl/fb_rect_writer.sv
// fb_rect_writer: clipped solid-rectangle fill into the frame buffer.
// FB_RECT_OUTLINE_EN adds an outline-only drawing mode.
module fb_rect_writer
  import fb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [8:0]        x0,
  input  logic [7:0]        y0,
  input  logic [8:0]        w,
  input  logic [7:0]        h,
  input  logic [COLOR_W-1:0] color,
`ifdef FB_RECT_OUTLINE_EN
  input  logic              outline,
`endif
  output logic              busy,
  output logic              done,
  output logic              fb_we,
  input  logic              fb_gnt,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [COLOR_W-1:0] fb_data
);

  state_t state, state_nx;

  logic [8:0] x0_q, w_q, x_q, xe_q;
  logic [7:0] y0_q, h_q, y_q, ye_q;
  color_t     color_q;
  addr_t      row_q;
  logic       outline_q;

  logic [9:0] xs, ys;
  logic [8:0] xe_c;
  logic [7:0] ye_c;
  logic       empty;

  assign xs    = {1'b0, x0_q} + {1'b0, w_q};
  assign ys    = {2'b0, y0_q} + {2'b0, h_q};
  assign xe_c  = (xs > 10'(FB_W)) ? 9'(FB_W) : xs[8:0];
  assign ye_c  = (ys > 10'(FB_H)) ? 8'(FB_H) : ys[7:0];
  assign empty = (w_q == '0) || (h_q == '0) ||
                 (x0_q >= 9'(FB_W)) || (y0_q >= 8'(FB_H));

  logic  last_col, last_row, edge_row;
  logic  wrap, skip, step, last_px;
  addr_t next_row;

  assign last_col = (x_q == xe_q - 9'd1);
  assign last_row = (y_q == ye_q - 8'd1);
  assign edge_row = (y_q == y0_q) || last_row;
  assign last_px  = last_col && last_row;
  assign wrap     = last_col && !last_row;
  // interior rows of an outline jump from the left to the right edge
  assign skip     = outline_q && !edge_row && !last_col && (x_q == x0_q);
  assign step     = !last_col && !skip;
  assign next_row = row_q + addr_t'(FB_W);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = SETUP;
      SETUP:   state_nx = empty ? FINISH : WRITE;
      WRITE:   if (fb_gnt && last_px) state_nx = FINISH;
      FINISH:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy  = (state == SETUP) || (state == WRITE);
    done  = (state == FINISH);
    fb_we = (state == WRITE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x0_q      <= '0;
      y0_q      <= '0;
      w_q       <= '0;
      h_q       <= '0;
      color_q   <= '0;
      outline_q <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      xe_q      <= '0;
      ye_q      <= '0;
      row_q     <= '0;
      fb_addr   <= '0;
      fb_data   <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          x0_q    <= x0;
          y0_q    <= y0;
          w_q     <= w;
          h_q     <= h;
          color_q <= color;
`ifdef FB_RECT_OUTLINE_EN
          outline_q <= outline;
`else
          outline_q <= 1'b0;
`endif
        end
        SETUP: begin
          xe_q    <= xe_c;
          ye_q    <= ye_c;
          x_q     <= x0_q;
          y_q     <= y0_q;
          fb_data <= color_q;
          if (!empty) begin
            row_q   <= row_addr(y0_q);
            fb_addr <= row_addr(y0_q) + addr_t'(x0_q);
          end
        end
        WRITE: if (fb_gnt) begin
          unique case (1'b1)
            wrap: begin
              x_q     <= x0_q;
              y_q     <= y_q + 8'd1;
              row_q   <= next_row;
              fb_addr <= next_row + addr_t'(x0_q);
            end
            skip: begin
              x_q     <= xe_q - 9'd1;
              fb_addr <= row_q + addr_t'(xe_q - 9'd1);
            end
            step: begin
              x_q     <= x_q + 9'd1;
              fb_addr <= fb_addr + addr_t'(1);
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fb_rect_writer.sv
// tb_fb_rect_writer: scoreboard bench for fb_rect_writer.
// Reference model enumerates clipped pixels directly.
module tb_fb_rect_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [8:0]  x0, w;
  logic [7:0]  y0, h;
  logic [11:0] color;
  logic        ol;
  logic        busy, done, fb_we, fb_gnt;
  logic [16:0] fb_addr;
  logic [11:0] fb_data;

  int checks   = 0;
  int failures = 0;
  int gnt_mode = 0;
  int phase    = 0;

  logic [28:0] exp_q[$];

  fb_rect_writer dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .x0      (x0),
    .y0      (y0),
    .w       (w),
    .h       (h),
    .color   (color),
`ifdef FB_RECT_OUTLINE_EN
    .outline (ol),
`endif
    .busy    (busy),
    .done    (done),
    .fb_we   (fb_we),
    .fb_gnt  (fb_gnt),
    .fb_addr (fb_addr),
    .fb_data (fb_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  initial begin
    fb_gnt = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (gnt_mode)
        0: fb_gnt = 1'b1;
        1: begin
          phase  = (phase + 1) % 3;
          fb_gnt = (phase == 0);
        end
        default: fb_gnt = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // monitor: every committed write must match the next expected pixel
  initial begin
    logic        hold;
    logic [16:0] hold_addr;
    logic [28:0] e;
    hold = 1'b0;
    hold_addr = '0;
    forever begin
      @(negedge clk);
      if (!rst) hold = 1'b0;
      else if (fb_we) begin
        if (hold) check("hold_addr", 32'(fb_addr), 32'(hold_addr));
        check("addr_range", 32'(fb_addr <= 17'd76799), 32'd1);
        if (fb_gnt) begin
          hold = 1'b0;
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_write actual=%0d required=none",
                     fb_addr);
          end else begin
            e = exp_q.pop_front();
            check("wr_addr", 32'(fb_addr), 32'(e[28:12]));
            check("wr_data", 32'(fb_data), 32'(e[11:0]));
          end
        end else begin
          hold = 1'b1;
          hold_addr = fb_addr;
        end
      end else hold = 1'b0;
    end
  end

  function automatic int model(input int cx, cy, cw, ch, cc, input bit o);
    int n = 0;
    int xe = (cx + cw < 320) ? cx + cw : 320;
    int ye = (cy + ch < 240) ? cy + ch : 240;
    for (int yy = cy; yy < ye; yy++)
      for (int xx = cx; xx < xe; xx++)
        if (!o || yy == cy || yy == ye - 1 || xx == cx || xx == xe - 1) begin
          exp_q.push_back({17'(yy * 320 + xx), 12'(cc)});
          n++;
        end
    return n;
  endfunction

  task automatic run_cmd(input int cx, cy, cw, ch, cc, input bit o,
                         input bit poke);
    int  n, cyc;
    bit  got;
    n = model(cx, cy, cw, ch, cc, o);
    @(negedge clk);
    x0 = 9'(cx); y0 = 8'(cy); w = 9'(cw); h = 8'(ch);
    color = 12'(cc); ol = o; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 0;
    got = 0;
    while (!got && cyc < 8000) begin
      @(negedge clk);
      cyc++;
      if (poke && (cyc == 3 || cyc == 6)) begin
        x0 = 9'd100; y0 = 8'd100; w = 9'd5; h = 8'd5; start = 1'b1;
      end else start = 1'b0;
      if (done) got = 1;
    end
    start = 1'b0;
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL done_timeout actual=%0d required=%0d", cyc, 2 + n);
    end else begin
      if (gnt_mode == 0) check("latency", 32'(cyc), 32'(2 + n));
      check("busy_at_done", 32'(busy), 32'd0);
      @(negedge clk);
      check("done_pulse", 32'(done), 32'd0);
      @(negedge clk);
      check("busy_after", 32'(busy), 32'd0);
    end
    check("pending", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; ol = 1'b0;
    x0 = '0; y0 = '0; w = '0; h = '0; color = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_fb_we", 32'(fb_we), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("rst_done", 32'(done), 32'd0);
    check("rst_addr", 32'(fb_addr), 32'd0);
    check("rst_data", 32'(fb_data), 32'd0);

    gnt_mode = 0;
    run_cmd(10, 5, 3, 2, 'hF00, 0, 0);
    run_cmd(318, 239, 5, 5, 'h0A5, 0, 0);
    run_cmd(10, 5, 0, 4, 'h123, 0, 0);
    run_cmd(320, 5, 4, 4, 'h456, 0, 0);
    run_cmd(10, 240, 4, 4, 'h789, 0, 0);

    gnt_mode = 1;
    run_cmd(0, 0, 4, 1, 'h0F0, 0, 1);

    // abort mid-command with reset
    gnt_mode = 0;
    void'(model(0, 10, 50, 3, 'h333, 0));
    @(negedge clk);
    x0 = 9'd0; y0 = 8'd10; w = 9'd50; h = 8'd3; color = 12'h333;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (8) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("async_we", 32'(fb_we), 32'd0);
    check("async_busy", 32'(busy), 32'd0);
    exp_q.delete();
    repeat (3) begin
      @(negedge clk);
      check("rst_hold_we", 32'(fb_we), 32'd0);
    end
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("post_rst_we", 32'(fb_we), 32'd0);
    end
    run_cmd(10, 5, 3, 2, 'hF00, 0, 0);

`ifdef FB_RECT_OUTLINE_EN
    run_cmd(0, 0, 4, 3, 'hFFF, 1, 0);
    run_cmd(316, 237, 8, 8, 'h00F, 1, 0);
`endif

    for (int i = 0; i < 24; i++) begin
      bit o = 0;
`ifdef FB_RECT_OUTLINE_EN
      o = 1'($urandom_range(0, 1));
`endif
      gnt_mode = (i % 2 == 0) ? 0 : 2;
      run_cmd(int'($urandom_range(0, 340)), int'($urandom_range(0, 250)),
              int'($urandom_range(0, 24)), int'($urandom_range(0, 10)),
              int'($urandom_range(0, 4095)), o, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
